// File: rtl/datapath_share_arbiter_pkg.sv
// Shared types and constants for the datapath share arbiter.
package datapath_share_arbiter_pkg;

  // Operand/result width of the shared datapath.
  localparam int DW = 3;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Three-input majority, used as the carry-in of the adder path.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/datapath_share_arbiter_rr_arbiter.sv
// Stateless round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  win_id_o,
  output logic [NREQ-1:0] win_oh_o,
  output logic            any_o
);
  int idx;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    win_id_o = '0;
    win_oh_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        win_id_o      = IDW'(idx);
        win_oh_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/instantiation_circuit.sv
// Shared datapath: per-bit combinational cell array or a 3-operand adder.

// Per-bit cell: a selects between b (a=1) and c (a=0).
module example_combinational_rtl (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = (a_i & b_i) | (~a_i & c_i);
endmodule

module instantiation_circuit
  import datapath_share_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  input  logic         sel_i,
  output logic [N-1:0] y_o
);
  logic         cin;
  logic [N-1:0] sum;
  logic [N-1:0] mix;

  // Carry-in is the majority of the three top bits of c; carry-out is dropped.
  assign cin = maj3(c_i[2], c_i[1], c_i[0]);
  assign sum = a_i + b_i + {{(N-1){1'b0}}, cin};

  for (genvar i = 0; i < N; i++) begin : g_bit
    example_combinational_rtl u_cell (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c_i[i]),
      .y_o (mix[i])
    );
  end

  assign y_o = sel_i ? sum : mix;
endmodule

// File: rtl/datapath_share_arbiter.sv
// Time-shares one datapath among NREQ requesters: grant, load, execute, respond.
module datapath_share_arbiter
  import datapath_share_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [DW*NREQ-1:0]   a_bus_i,
  input  logic [DW*NREQ-1:0]   b_bus_i,
  input  logic [DW*NREQ-1:0]   c_bus_i,
  input  logic [NREQ-1:0]      sel_bus_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [DW-1:0]        y_o,
  output logic [IDW-1:0]       y_id_o,
  output logic                 y_valid_o,
  output logic                 busy_o
);
  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_nxt;
  logic [IDW-1:0]  win_id_q;
  logic [NREQ-1:0] gnt_q;
  logic [DW-1:0]   opa_q, opb_q, opc_q;
  logic            opsel_q;
  logic [DW-1:0]   y_q;
  logic [IDW-1:0]  y_id_q;
  logic            y_valid_q;

  logic [IDW-1:0]  arb_id;
  logic [NREQ-1:0] arb_oh;
  logic            arb_any;
  logic [DW-1:0]   a_sel, b_sel, c_sel;
  logic            s_sel;
  logic [DW-1:0]   dp_y;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .win_id_o (arb_id),
    .win_oh_o (arb_oh),
    .any_o    (arb_any)
  );

  // Operand slices of the current winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;
    s_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id_q == IDW'(i)) begin
        a_sel = a_bus_i[DW*i +: DW];
        b_sel = b_bus_i[DW*i +: DW];
        c_sel = c_bus_i[DW*i +: DW];
        s_sel = sel_bus_i[i];
      end
    end
  end

  // Datapath sees only the operand registers, never the live buses.
  instantiation_circuit #(.N(DW)) u_dp (
    .a_i   (opa_q),
    .b_i   (opb_q),
    .c_i   (opc_q),
    .sel_i (opsel_q),
    .y_o   (dp_y)
  );

  assign ptr_nxt = (win_id_q == IDW'(NREQ-1)) ? '0 : win_id_q + 1'b1;

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Fixed four-step cycle; IDLE waits for any request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_any) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, operand capture, result and pointer registers stepped by state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q     <= '0;
      win_id_q  <= '0;
      gnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      opsel_q   <= 1'b0;
      y_q       <= '0;
      y_id_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (arb_any) begin
          gnt_q    <= arb_oh;
          win_id_q <= arb_id;
        end
        ST_LOAD: begin
          opa_q   <= a_sel;
          opb_q   <= b_sel;
          opc_q   <= c_sel;
          opsel_q <= s_sel;
          gnt_q   <= '0;
        end
        ST_EXEC: begin
          y_q       <= dp_y;
          y_id_q    <= win_id_q;
          y_valid_q <= 1'b1;
        end
        ST_RESP: begin
          y_valid_q <= 1'b0;
          ptr_q     <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign y_o       = y_q;
  assign y_id_o    = y_id_q;
  assign y_valid_o = y_valid_q;
  assign busy_o    = (state_q != ST_IDLE);
endmodule
